// File: rtl/yutorina_intc_if.sv
// Bus bundle between the interrupt controller and the CPU control unit / SPR port.
// Combinational wiring only, no latency.
// No backpressure; stall qualifies int_ack/eret inside the controller.
interface yutorina_intc_if #(
    parameter int IRQ_CH = 8
);
    logic [IRQ_CH-1:0] irq;
    logic              int_req;
    logic              int_ack;
    logic              eret;
    logic              stall;
    logic [2:0]        r_addr;
    logic [31:0]       r_data;
    logic [2:0]        w_addr;
    logic              we_;
    logic [31:0]       w_data;

    modport master (
        output irq, int_ack, eret, stall, r_addr, w_addr, we_, w_data,
        input  int_req, r_data
    );

    modport slave (
        input  irq, int_ack, eret, stall, r_addr, w_addr, we_, w_data,
        output int_req, r_data
    );
endinterface

// File: rtl/yutorina_intc.sv
// External interrupt controller: sync/latch IRQs, mask+IE, single request, ack/ERET handshake.
// Latency: irq rise -> PEND after 3 edges, int_req one edge later; r_data combinational.
// Backpressure: int_ack/eret ignored while stall is high. Optional edge mode: YUTORINA_INTC_EDGE_EN.
module yutorina_intc #(
    parameter int IRQ_CH  = 8,
    parameter int CAUSE_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    yutorina_intc_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

    state_t               state_q, state_d;
    logic [IRQ_CH-1:0]    sync1_q, sync1_d;
    logic [IRQ_CH-1:0]    sync2_q, sync2_d;
    logic [IRQ_CH-1:0]    pend_q, pend_d;
    logic [IRQ_CH-1:0]    mask_q, mask_d;
    logic                 ie_q, ie_d;
    logic                 cause_vld_q, cause_vld_d;
    logic [CAUSE_W-1:0]   cause_idx_q, cause_idx_d;
    logic                 int_req_q, int_req_d;
`ifdef YUTORINA_INTC_EDGE_EN
    logic [IRQ_CH-1:0]    sync3_q, sync3_d;
    logic [IRQ_CH-1:0]    mode_q, mode_d;
`endif

    logic                 wr;
    logic [IRQ_CH-1:0]    clr;
    logic [IRQ_CH-1:0]    set;
    logic [IRQ_CH-1:0]    act;
    logic                 elig;
    logic [CAUSE_W-1:0]   low_idx;
    logic [31:0]          rdata;
    logic                 unused_wdata;

    assign unused_wdata = ^bus.w_data;

    always_comb begin
        sync1_d     = bus.irq;
        sync2_d     = sync1_q;
        mask_d      = mask_q;
        ie_d        = ie_q;
        state_d     = state_q;
        cause_vld_d = cause_vld_q;
        cause_idx_d = cause_idx_q;
        low_idx     = '0;

        wr  = !bus.we_;
        clr = (wr && bus.w_addr == 3'd1) ? bus.w_data[IRQ_CH-1:0] : '0;
        if (wr && bus.w_addr == 3'd0) mask_d = bus.w_data[IRQ_CH-1:0];
        if (wr && bus.w_addr == 3'd3) ie_d = bus.w_data[0];

`ifdef YUTORINA_INTC_EDGE_EN
        sync3_d = sync2_q;
        mode_d  = mode_q;
        if (wr && bus.w_addr == 3'd4) mode_d = bus.w_data[IRQ_CH-1:0];
        set = (sync2_q & ~mode_q) | (sync2_q & ~sync3_q & mode_q);
`else
        set = sync2_q;
`endif
        // set is OR'd after the clear so a live source wins over W1C
        pend_d = (pend_q & ~clr) | set;

        act  = pend_q & mask_q;
        elig = (|act) & ie_q;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (act[i]) low_idx = CAUSE_W'(i);
        end

        case (state_q)
            ST_IDLE: begin
                if (elig) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.int_ack && !bus.stall) begin
                    state_d     = ST_SERVICE;
                    cause_vld_d = 1'b1;
                    cause_idx_d = low_idx;
                end else if (!elig) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eret && !bus.stall) begin
                    state_d     = ST_IDLE;
                    cause_vld_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        int_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            ie_q        <= 1'b0;
            cause_vld_q <= 1'b0;
            cause_idx_q <= '0;
            int_req_q   <= 1'b0;
`ifdef YUTORINA_INTC_EDGE_EN
            sync3_q     <= '0;
            mode_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            ie_q        <= ie_d;
            cause_vld_q <= cause_vld_d;
            cause_idx_q <= cause_idx_d;
            int_req_q   <= int_req_d;
`ifdef YUTORINA_INTC_EDGE_EN
            sync3_q     <= sync3_d;
            mode_q      <= mode_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.r_addr)
            3'd0: rdata = 32'(mask_q);
            3'd1: rdata = 32'(pend_q);
            3'd2: rdata = {cause_vld_q, 31'(cause_idx_q)};
            3'd3: rdata = {30'd0, (state_q == ST_SERVICE), ie_q};
`ifdef YUTORINA_INTC_EDGE_EN
            3'd4: rdata = 32'(mode_q);
`endif
            default: rdata = '0;
        endcase
    end

    assign bus.r_data  = rdata;
    assign bus.int_req = int_req_q;
endmodule
